key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
Multi-key front-end controller. It sequences a shared sample-tick for NUM_KEYS per-key debounce channels, derives press, release and long-press events, and round-robin arbitrates them onto one valid/ready event stream. It sits between the board push-buttons (active-low) and the camera control FSM, so the FSM handles one event at a time.

Parameters:
NUM_KEYS, 4, number of key inputs (1..16)
TICK_DIV, 1000, clk cycles per sample tick (>=2)
STABLE_TICKS, 15, consecutive differing samples needed to flip a debounced level (>=1)
LONG_TICKS, 2000, ticks of debounced-pressed level before a long event (>STABLE_TICKS)
KW, $clog2(NUM_KEYS) min 1, key index width (derived localparam)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
key_in  in  NUM_KEYS  raw asynchronous keys; 0 = pressed
key_level  out  NUM_KEYS  debounced level; 1 = pressed
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts when valid && ready
evt_key  out  KW  key index of event
evt_code  out  2  01 press, 10 release, 11 long
evt_overflow  out  1  sticky; an event was dropped
clr_overflow  in  1  clears evt_overflow

Behaviour:
- Reset (rst sampled high at a clk edge): key_level=0, evt_valid=0, evt_key=0, evt_code=00, evt_overflow=0. All counters, sync flops, pending flags and the RR pointer are cleared. Reset mid-operation discards pending events; a key still held is re-detected from scratch.
- Input sync: 2-FF synchroniser per key, then inverted (pressed=1).
- Tick: counter runs 0..TICK_DIV-1. tick=1 for one cycle when count==TICK_DIV-1, then wraps to 0.
- Per-key debounce on tick:
  - If sample != key_level: increment cnt.
  - When cnt reaches STABLE_TICKS: toggle key_level, clear cnt, and set pending press (0->1) or pending release (1->0).
  - If sample == key_level: cnt=0.
  - Glitch shorter than STABLE_TICKS ticks gives no event.
- Long press: long counter clears on a level rise and counts ticks while key_level=1. At count==LONG_TICKS, set pending long once, then saturate. A release clears it.
- Pending flags: 3 per key (press, long, release).
  - Flag already set when a new event of the same type arrives: event dropped, evt_overflow set.
  - Grant clear and new set of the same flag in the same cycle: set wins, no overflow.
  - clr_overflow and a new overflow in the same cycle: overflow stays 1.
- Arbiter:
  - Output register loads when evt_valid==0 or (evt_valid && evt_ready).
  - Scan keys round-robin, starting at ptr.
  - Within a key, priority is press > long > release, which preserves order for slow consumers.
  - On load: evt_valid=1, evt_key and evt_code are set, the granted flag is cleared, and ptr = granted key+1 (mod NUM_KEYS).
  - No pending flag: evt_valid=0, evt_code=00.
  - evt_key and evt_code stay stable while valid && !ready. Back-to-back events are accepted at 1 per cycle.
- Latency: debounced flip occurs on the cycle after the tick. Pending is set with it. evt_valid follows 1 cycle later if the output register is free.

Decomposition:
- Package key_evt_pkg holds EVT_NONE=2'b00, EVT_PRESS=2'b01, EVT_RELEASE=2'b10, EVT_LONG=2'b11.
- Sub-module key_debounce_chan (sync, debounce counter, long counter, press/release/long strobes) is generate-instantiated NUM_KEYS times.
- key_event_ctrl holds the tick divider, pending flags, overflow and the RR arbiter.

Test Plan:
(All tests use NUM_KEYS=4, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8, evt_ready=1 unless stated.)
- Glitch: key_in[0]=0 for 8 clk (2 ticks), then 1 -> key_level[0] stays 0, evt_valid never 1.
- Clean press: key_in[1]=0 held 20 clk -> key_level[1]=1 after the 3rd tick. Exactly one event, key=1, code=01, valid for one cycle.
- Long and release: key_in[2]=0 held 60 clk, then 1 for 20 clk -> events in order (2,01), (2,11) once, (2,10). key_level[2] returns to 0.
- Arbitration/hold: keys 0 and 3 pressed together, evt_ready=0 -> evt_valid=1, evt_key=0, code=01 held for 10 cycles. Then ready=1 -> key 0 accepted, then key 3 next cycle.
- Overflow: evt_ready=0, key0 press, release, press (each held 20 clk) -> evt_overflow=1. Later accepted events are (0,01), (0,10) only. clr_overflow pulse -> evt_overflow=0.
- Reset mid-hold: key_in[1]=0 held, press pending, rst pulsed 1 cycle -> next cycle all outputs 0. Key still held -> (1,01) re-issued after 3 further ticks.

Source files
------------

// File: rtl/key_evt_pkg.sv
// Shared event codes and sizing helper for the multi-key event controller.
package key_evt_pkg;
  localparam logic [1:0] EVT_NONE    = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_LONG    = 2'b11;

  function automatic int key_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-FF sync, tick-driven debounce and long-press timer.
// Event strobes are combinational so the owner can latch them on the same edge the level flips.
module key_debounce_chan import key_evt_pkg::*; #(
  parameter int STABLE_TICKS = 15,
  parameter int LONG_TICKS   = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  input  logic tick,
  output logic level,
  output logic press,
  output logic fall,
  output logic long_press
);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);

  // Inverted on entry so a cleared synchroniser reads as "released".
  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [SW-1:0] cnt_reg;
  logic [LW-1:0] long_reg;
  logic          sample;
  logic          flip;

  assign sample     = sync_reg[1];
  assign flip       = tick && (sample != level_reg) && (cnt_reg == SW'(STABLE_TICKS - 1));
  assign press      = flip && !level_reg;
  assign fall       = flip && level_reg;
  assign long_press = tick && level_reg && (long_reg == LW'(LONG_TICKS - 1));
  assign level      = level_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      long_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], ~key_raw};
      if (tick) begin
        if (sample == level_reg) begin
          cnt_reg <= '0;
        end else if (flip) begin
          level_reg <= ~level_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        // Saturates at LONG_TICKS so the long strobe fires once per hold.
        if (flip) begin
          long_reg <= '0;
        end else if (level_reg && (long_reg != LW'(LONG_TICKS))) begin
          long_reg <= long_reg + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key front end: shared sample tick, per-key pending flags with overflow
// detection, and a round-robin arbiter onto a single valid/ready event stream.
module key_event_ctrl import key_evt_pkg::*; #(
  parameter int NUM_KEYS     = 4,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 15,
  parameter int LONG_TICKS   = 2000,
  localparam int KW          = key_w(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_key,
  output logic [1:0]          evt_code,
  output logic                evt_overflow,
  input  logic                clr_overflow
);
  localparam int TW = $clog2(TICK_DIV);

  logic [TW-1:0]       tick_cnt_reg;
  logic                tick;
  logic [NUM_KEYS-1:0] press_set, long_set, rel_set;
  logic [NUM_KEYS-1:0] press_pend_reg, long_pend_reg, rel_pend_reg;
  logic [NUM_KEYS-1:0] press_clr, long_clr, rel_clr;
  logic [NUM_KEYS-1:0] press_next, long_next, rel_next;
  logic [NUM_KEYS-1:0] any_pend, gnt_onehot;
  logic [KW-1:0]       ptr_reg, ptr_next, gnt_key;
  logic [1:0]          gnt_code;
  logic                found, load, grant, ovf_hit, ovf_next;
  logic                evt_valid_reg, evt_overflow_reg;
  logic [KW-1:0]       evt_key_reg;
  logic [1:0]          evt_code_reg;

  assign tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
    key_debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_in[gi]),
      .tick      (tick),
      .level     (key_level[gi]),
      .press     (press_set[gi]),
      .fall      (rel_set[gi]),
      .long_press(long_set[gi])
    );
  end

  assign any_pend = press_pend_reg | long_pend_reg | rel_pend_reg;

  // First key with anything pending, scanning upward from the RR pointer.
  always_comb begin
    int          scan;
    logic [KW-1:0] idx;
    found   = 1'b0;
    gnt_key = '0;
    scan    = 0;
    idx     = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      scan = (int'(ptr_reg) + i) % NUM_KEYS;
      idx  = KW'(scan);
      if (!found && any_pend[idx]) begin
        found   = 1'b1;
        gnt_key = idx;
      end
    end
  end

  // Press before long before release keeps one key's events in order.
  assign gnt_code = press_pend_reg[gnt_key] ? EVT_PRESS :
                    long_pend_reg[gnt_key]  ? EVT_LONG  : EVT_RELEASE;
  assign load       = !evt_valid_reg || evt_ready;
  assign grant      = load && found;
  assign gnt_onehot = grant ? (NUM_KEYS'(1) << gnt_key) : '0;
  assign press_clr  = gnt_onehot & {NUM_KEYS{gnt_code == EVT_PRESS}};
  assign long_clr   = gnt_onehot & {NUM_KEYS{gnt_code == EVT_LONG}};
  assign rel_clr    = gnt_onehot & {NUM_KEYS{gnt_code == EVT_RELEASE}};
  assign ptr_next   = (gnt_key == KW'(NUM_KEYS - 1)) ? '0 : gnt_key + 1'b1;

  // A flag being granted this cycle is free to take a new event without loss.
  assign press_next = (press_pend_reg & ~press_clr) | press_set;
  assign long_next  = (long_pend_reg & ~long_clr) | long_set;
  assign rel_next   = (rel_pend_reg & ~rel_clr) | rel_set;
  assign ovf_hit    = |((press_pend_reg & ~press_clr & press_set) |
                        (long_pend_reg & ~long_clr & long_set) |
                        (rel_pend_reg & ~rel_clr & rel_set));
  assign ovf_next   = (evt_overflow_reg & ~clr_overflow) | ovf_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_reg     <= '0;
      press_pend_reg   <= '0;
      long_pend_reg    <= '0;
      rel_pend_reg     <= '0;
      ptr_reg          <= '0;
      evt_valid_reg    <= 1'b0;
      evt_key_reg      <= '0;
      evt_code_reg     <= EVT_NONE;
      evt_overflow_reg <= 1'b0;
    end else begin
      tick_cnt_reg     <= tick ? '0 : tick_cnt_reg + 1'b1;
      press_pend_reg   <= press_next;
      long_pend_reg    <= long_next;
      rel_pend_reg     <= rel_next;
      evt_overflow_reg <= ovf_next;
      if (load) begin
        evt_valid_reg <= found;
        evt_code_reg  <= found ? gnt_code : EVT_NONE;
        if (found) begin
          evt_key_reg <= gnt_key;
          ptr_reg     <= ptr_next;
        end
      end
    end
  end

  assign evt_valid    = evt_valid_reg;
  assign evt_key      = evt_key_reg;
  assign evt_code     = evt_code_reg;
  assign evt_overflow = evt_overflow_reg;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Scenario bench for key_event_ctrl against an event-list reference model.
module tb_key_event_ctrl;
  import key_evt_pkg::*;
  localparam int NK = 4, TD = 4, ST = 3, LT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_level;
  logic          evt_valid, evt_overflow;
  logic          evt_ready = 1'b1;
  logic          clr_overflow = 1'b0;
  logic [1:0]    evt_key;
  logic [1:0]    evt_code;

  always #5 clk = ~clk;

  key_event_ctrl #(
    .NUM_KEYS(NK), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LT)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_code(evt_code), .evt_overflow(evt_overflow), .clr_overflow(clr_overflow)
  );

  int vectors = 0, miscompares = 0;

  // Reference model: delayed raw samples, tick schedule, run lengths, hold time.
  int m_cyc;
  bit m_h1[NK], m_h2[NK], m_lvl[NK];
  int m_run[NK], m_held[NK];
  int exp_q[NK][$];
  bit chk_q = 1'b1;
  int cyc_abs = 0;
  typedef struct { int key; int code; int cyc; } evt_t;
  evt_t got[$];

  task automatic model_step(input bit r, input logic [NK-1:0] k);
    bit tick, s;
    if (r) begin
      m_cyc = 0;
      for (int i = 0; i < NK; i++) begin
        m_h1[i] = 0; m_h2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_held[i] = 0;
        exp_q[i].delete();
      end
    end else begin
      tick = (m_cyc % TD) == TD - 1;
      m_cyc++;
      for (int i = 0; i < NK; i++) begin
        s = m_h2[i];
        m_h2[i] = m_h1[i];
        m_h1[i] = !k[i];
        if (tick) begin
          if (m_lvl[i] && m_held[i] < LT) begin
            m_held[i]++;
            if (m_held[i] == LT) exp_q[i].push_back(3);
          end
          if (s != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == ST) begin
              m_run[i] = 0;
              m_lvl[i] = s;
              exp_q[i].push_back(s ? 1 : 2);
              if (s) m_held[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    bit hs, hold;
    logic [1:0] pk, pc;
    logic [NK-1:0] exp_lvl;
    int e;
    hs   = (evt_valid === 1'b1) && evt_ready && !rst;
    hold = (evt_valid === 1'b1) && !evt_ready && !rst;
    pk = evt_key;
    pc = evt_code;
    if (hs) begin
      got.push_back('{key: int'(pk), code: int'(pc), cyc: cyc_abs});
      if (chk_q) begin
        vectors++;
        if (exp_q[int'(pk)].size() == 0) begin
          miscompares++;
          $display("FAIL evt_order: accepted key %0d code %b, expected no event for that key", pk, pc);
        end else begin
          e = exp_q[int'(pk)].pop_front();
          if (int'(pc) != e) begin
            miscompares++;
            $display("FAIL evt_order: key %0d code %b, expected code %0d", pk, pc, e);
          end
        end
      end
    end
    @(posedge clk);
    model_step(rst, key_in);
    cyc_abs++;
    #1;
    if (hold) begin
      vectors++;
      if (evt_valid !== 1'b1 || evt_key !== pk || evt_code !== pc) begin
        miscompares++;
        $display("FAIL evt_hold: valid %b key %0d code %b, expected 1 %0d %b", evt_valid, evt_key, evt_code, pk, pc);
      end
    end
    for (int i = 0; i < NK; i++) exp_lvl[i] = m_lvl[i];
    vectors++;
    if (key_level !== exp_lvl) begin
      miscompares++;
      $display("FAIL key_level: got %b expected %b (cycle %0d)", key_level, exp_lvl, cyc_abs);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    key_in = '1; evt_ready = 1'b1; clr_overflow = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (key_level !== '0 || evt_valid !== 1'b0 || evt_key !== 2'd0 || evt_code !== EVT_NONE || evt_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: level %b valid %b key %0d code %b ovf %b, expected all 0",
               key_level, evt_valid, evt_key, evt_code, evt_overflow);
    end
  endtask

  task automatic test_glitch();
    bit seen_v, seen_l;
    test_reset();
    seen_v = 0; seen_l = 0;
    key_in[0] = 1'b0;
    for (int n = 0; n < 28; n++) begin
      if (n == 8) key_in[0] = 1'b1;
      step();
      seen_v |= (evt_valid === 1'b1);
      seen_l |= (key_level[0] === 1'b1);
    end
    vectors++;
    if (seen_v || seen_l) begin
      miscompares++;
      $display("FAIL glitch: valid_seen %b level_seen %b, expected 0 0", seen_v, seen_l);
    end
  endtask

  task automatic test_clean_press();
    int lvl_step, vld_step, vcnt, base;
    test_reset();
    lvl_step = -1; vld_step = -1; vcnt = 0; base = got.size();
    key_in[1] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (key_level[1] === 1'b1 && lvl_step < 0) lvl_step = n;
      if (evt_valid === 1'b1 && vld_step < 0) vld_step = n;
      if (evt_valid === 1'b1) vcnt++;
    end
    vectors++;
    if (lvl_step != 12 || vld_step != 13) begin
      miscompares++;
      $display("FAIL press_latency: level at %0d valid at %0d, expected 12 13", lvl_step, vld_step);
    end
    vectors++;
    if (vcnt != 1 || got.size() != base + 1) begin
      miscompares++;
      $display("FAIL press_count: valid cycles %0d events %0d, expected 1 1", vcnt, got.size() - base);
    end else if (got[base].key != 1 || got[base].code != 1) begin
      miscompares++;
      $display("FAIL press_event: key %0d code %0d, expected 1 1", got[base].key, got[base].code);
    end
    key_in = '1;
    run(20);
  endtask

  task automatic test_long_release();
    int base;
    int exp_codes[3];
    exp_codes = '{1, 3, 2};
    test_reset();
    base = got.size();
    key_in[2] = 1'b0;
    run(60);
    key_in[2] = 1'b1;
    run(20);
    vectors++;
    if (got.size() != base + 3) begin
      miscompares++;
      $display("FAIL long_count: got %0d events, expected 3", got.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (got[base+i].key != 2 || got[base+i].code != exp_codes[i]) begin
          miscompares++;
          $display("FAIL long_seq[%0d]: key %0d code %0d, expected 2 %0d", i, got[base+i].key, got[base+i].code, exp_codes[i]);
        end
      end
    end
    vectors++;
    if (key_level[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL long_level: key_level[2] %b, expected 0", key_level[2]);
    end
  endtask

  task automatic test_arbitration();
    int n, base;
    test_reset();
    evt_ready = 1'b0;
    key_in = 4'b0110;
    n = 0;
    while (evt_valid !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (evt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arb_timeout: valid %b after %0d cycles, expected 1", evt_valid, n);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (evt_valid !== 1'b1 || evt_key !== 2'd0 || evt_code !== EVT_PRESS) begin
        miscompares++;
        $display("FAIL arb_hold: valid %b key %0d code %b, expected 1 0 01", evt_valid, evt_key, evt_code);
      end
    end
    base = got.size();
    evt_ready = 1'b1;
    step();
    step();
    vectors++;
    if (got.size() < base + 2) begin
      miscompares++;
      $display("FAIL arb_b2b: got %0d events in 2 cycles, expected 2", got.size() - base);
    end else if (got[base].key != 0 || got[base].code != 1 || got[base+1].key != 3 ||
                 got[base+1].code != 1 || got[base+1].cyc != got[base].cyc + 1) begin
      miscompares++;
      $display("FAIL arb_b2b: (%0d,%0d)@%0d (%0d,%0d)@%0d, expected (0,1) then (3,1) next cycle",
               got[base].key, got[base].code, got[base].cyc, got[base+1].key, got[base+1].code, got[base+1].cyc);
    end
    key_in = '1;
    run(30);
  endtask

  task automatic test_overflow();
    int base, k0[$];
    test_reset();
    chk_q = 1'b0;
    evt_ready = 1'b0;
    key_in[1] = 1'b0;
    run(16);
    base = got.size();
    key_in[0] = 1'b0; run(20);
    key_in[0] = 1'b1; run(20);
    key_in[0] = 1'b0; run(20);
    vectors++;
    if (evt_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: evt_overflow %b, expected 1", evt_overflow);
    end
    key_in = '1;
    evt_ready = 1'b1;
    run(8);
    for (int i = base; i < got.size(); i++) if (got[i].key == 0) k0.push_back(got[i].code);
    vectors++;
    if (k0.size() != 2 || k0[0] != 1 || k0[1] != 2) begin
      miscompares++;
      $display("FAIL ovf_events: key0 got %0d events (first %0d), expected codes 1 then 2",
               k0.size(), (k0.size() > 0) ? k0[0] : -1);
    end
    vectors++;
    if (evt_overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: evt_overflow %b, expected 1", evt_overflow);
    end
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    vectors++;
    if (evt_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear: evt_overflow %b, expected 0", evt_overflow);
    end
    chk_q = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    int n, base;
    test_reset();
    evt_ready = 1'b0;
    key_in[1] = 1'b0;
    run(16);
    vectors++;
    if (evt_valid !== 1'b1 || evt_key !== 2'd1) begin
      miscompares++;
      $display("FAIL rmid_pending: valid %b key %0d, expected 1 1", evt_valid, evt_key);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (key_level !== '0 || evt_valid !== 1'b0 || evt_key !== 2'd0 || evt_code !== EVT_NONE || evt_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_reset: level %b valid %b key %0d code %b ovf %b, expected all 0",
               key_level, evt_valid, evt_key, evt_code, evt_overflow);
    end
    evt_ready = 1'b1;
    base = got.size();
    n = 0;
    while (evt_valid !== 1'b1 && n < 40) begin step(); n++; end
    vectors++;
    if (n != 13 || evt_key !== 2'd1 || evt_code !== EVT_PRESS) begin
      miscompares++;
      $display("FAIL rmid_reissue: valid after %0d cycles key %0d code %b, expected 13 1 01", n, evt_key, evt_code);
    end
    key_in = '1;
    run(30);
  endtask

  task automatic test_random();
    int idx;
    test_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, NK - 1);
        key_in[idx] = ~key_in[idx];
      end
      evt_ready = ($urandom_range(0, 7) != 0);
      step();
    end
    key_in = '1;
    evt_ready = 1'b1;
    run(60);
    for (int i = 0; i < NK; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        miscompares++;
        $display("FAIL rand_drain: key %0d has %0d expected events never seen, expected 0", i, exp_q[i].size());
      end
    end
    vectors++;
    if (evt_overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_ovf: evt_overflow %b, expected 0", evt_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_long_release();
    test_arbitration();
    test_overflow();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
